// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 nibble-mode LCD paths: system clock, derived
// E-cycle timing and the read-engine state encoding.
package lcd_pkg;

  localparam int unsigned LCD_FREQ        = 50_000_000;
  localparam int unsigned LCD_T1_US       = LCD_FREQ / 1_000_000;
  localparam int unsigned LCD_T_SETUP_CYC = 2;
  localparam int unsigned LCD_T_EPH_CYC   = LCD_FREQ / 2_000_000;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StEHighHi,
    StELowHi,
    StEHighLo,
    StELowLo,
    StDone
  } lcd_read_state_t;

  // 500 ns E phase at the given clock frequency.
  function automatic int unsigned lcd_eph_cycles(input int unsigned freq);
    return freq / 2_000_000;
  endfunction

  function automatic int unsigned lcd_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// Loadable down counter with a zero flag; times the setup interval and every E phase.
module lcd_phase_timer #(
  parameter int unsigned Width = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [Width-1:0] i_value,
  output logic             o_zero
);

  logic [Width-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (r_count != '0) begin
      r_count <= r_count - Width'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/lcd_read.sv
// HD44780 nibble-mode read engine: two RW=1 E cycles return one status or data byte.
// Optional busy-flag polling is enabled by defining LCD_BUSY_POLL_EN.
module lcd_read
  import lcd_pkg::*;
#(
  parameter int unsigned FREQ        = LCD_FREQ,
  parameter int unsigned T_SETUP_CYC = LCD_T_SETUP_CYC,
  parameter int unsigned T_EPH_CYC   = lcd_eph_cycles(FREQ),
  parameter int unsigned POLL_MAX    = 1023
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       startRead,
  input  logic       readRS,
  inout  wire  [3:0] LCD_D,
  output logic       LCD_E,
  output logic       LCD_RW,
  output logic       LCD_RS,
  output logic [7:0] readData,
  output logic       readDone,
  output logic       busy,
  output logic       timeout
);

  localparam int unsigned MaxPhase = lcd_max(T_SETUP_CYC, T_EPH_CYC);
  localparam int unsigned CntW     = (MaxPhase > 1) ? $clog2(MaxPhase) : 1;

  if (POLL_MAX == 0 || T_SETUP_CYC == 0 || T_EPH_CYC == 0) begin : g_bad_cfg
    $error("lcd_read: POLL_MAX, T_SETUP_CYC and T_EPH_CYC must be non-zero");
  end

  lcd_read_state_t r_state;
  logic            r_e;
  logic            r_rw;
  logic            r_rs;
  logic            r_done;
  logic            r_busy;
  logic            r_timeout;
  logic [7:0]      r_data;

  logic            w_zero;
  logic            w_load;
  logic [CntW-1:0] w_load_val;
  logic            w_poll_again;
  logic            w_timeout_hit;

`ifdef LCD_BUSY_POLL_EN
  localparam int unsigned AttW = $clog2(POLL_MAX + 1);

  logic [AttW-1:0] r_attempts;

  // Re-read only status bytes that still report BF=1, up to POLL_MAX reads in total.
  assign w_poll_again  = !r_rs && r_data[7] && ((32'(r_attempts) + 32'd1) < POLL_MAX);
  assign w_timeout_hit = !r_rs && r_data[7];

  always_ff @(posedge CLK) begin
    if (RESET || r_state == StIdle) begin
      r_attempts <= '0;
    end else if (r_state == StELowLo && w_zero && w_poll_again) begin
      r_attempts <= r_attempts + AttW'(1);
    end
  end
`else
  assign w_poll_again  = 1'b0;
  assign w_timeout_hit = 1'b0;
`endif

  // The timer is reloaded on every phase boundary so its zero flag marks the phase's last cycle.
  always_comb begin
    w_load     = 1'b0;
    w_load_val = CntW'(T_EPH_CYC - 1);
    unique case (r_state)
      StIdle: begin
        if (startRead) begin
          w_load     = 1'b1;
          w_load_val = CntW'(T_SETUP_CYC - 1);
        end
      end
      StDone:  w_load = 1'b0;
      default: w_load = w_zero;
    endcase
  end

  lcd_phase_timer #(
    .Width (CntW)
  ) u_phase_timer (
    .i_clk   (CLK),
    .i_rst   (RESET),
    .i_load  (w_load),
    .i_value (w_load_val),
    .o_zero  (w_zero)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state   <= StIdle;
      r_e       <= 1'b0;
      r_rw      <= 1'b0;
      r_rs      <= 1'b0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
      r_data    <= 8'h00;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (startRead) begin
            r_state   <= StSetup;
            r_busy    <= 1'b1;
            r_rw      <= 1'b1;
            r_rs      <= readRS;
            r_timeout <= 1'b0;
          end
        end
        StSetup: begin
          if (w_zero) begin
            r_state <= StEHighHi;
            r_e     <= 1'b1;
          end
        end
        StEHighHi: begin
          if (w_zero) begin
            r_state     <= StELowHi;
            r_e         <= 1'b0;
            r_data[7:4] <= LCD_D;
          end
        end
        StELowHi: begin
          if (w_zero) begin
            r_state <= StEHighLo;
            r_e     <= 1'b1;
          end
        end
        StEHighLo: begin
          if (w_zero) begin
            r_state     <= StELowLo;
            r_e         <= 1'b0;
            r_data[3:0] <= LCD_D;
          end
        end
        StELowLo: begin
          if (w_zero) begin
            if (w_poll_again) begin
              r_state <= StEHighHi;
              r_e     <= 1'b1;
            end else begin
              r_state   <= StDone;
              r_done    <= 1'b1;
              r_timeout <= w_timeout_hit;
            end
          end
        end
        StDone: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
          r_rw    <= 1'b0;
          r_rs    <= 1'b0;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign LCD_E    = r_e;
  assign LCD_RW   = r_rw;
  assign LCD_RS   = r_rs;
  assign readData = r_data;
  assign readDone = r_done;
  assign busy     = r_busy;
  assign timeout  = r_timeout;

endmodule

// File: tb/tb_lcd_read.sv
// Self-checking bench for lcd_read: LCD bus model feeding nibbles on each E rise and a
// scoreboard of expected bytes/latency popped on readDone.
module tb_lcd_read;

  localparam int unsigned TSetup  = 2;
  localparam int unsigned TEph    = 25;
  localparam int unsigned PollMax = 4;
  localparam int unsigned ReadLat = 1 + TSetup + 4 * TEph;

  typedef struct packed {
    logic [7:0]  data;
    logic        tmo;
    logic [31:0] lat;
    logic        rs;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       rs_in = 1'b0;
  logic [3:0] bus_val = 4'hF;
  wire  [3:0] lcd_d;
  logic       lcd_e, lcd_rw, lcd_rs, read_done, busy, tmo;
  logic [7:0] read_data;

  assign lcd_d = bus_val;

  lcd_read #(
    .FREQ        (50_000_000),
    .T_SETUP_CYC (TSetup),
    .T_EPH_CYC   (TEph),
    .POLL_MAX    (PollMax)
  ) dut (
    .CLK       (clk),
    .RESET     (rst),
    .startRead (start),
    .readRS    (rs_in),
    .LCD_D     (lcd_d),
    .LCD_E     (lcd_e),
    .LCD_RW    (lcd_rw),
    .LCD_RS    (lcd_rs),
    .readData  (read_data),
    .readDone  (read_done),
    .busy      (busy),
    .timeout   (tmo)
  );

  always #10 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned cyc = 0;
  int unsigned t_start = 0;
  int unsigned e_run = 0;
  logic        e_prev = 1'b0;
  logic        chk_fall = 1'b0;
  exp_t        sb_q[$];
  exp_t        sb_e;
  logic [7:0]  bus_q[$];
  logic        nib_lo = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // LCD side: high nibble on the first E rise of a byte, low nibble on the second.
  always @(posedge lcd_e) begin
    if (!nib_lo) begin
      bus_val = (bus_q.size() > 0) ? bus_q[0][7:4] : 4'hF;
    end else begin
      bus_val = (bus_q.size() > 0) ? bus_q[0][3:0] : 4'hF;
      if (bus_q.size() > 0) void'(bus_q.pop_front());
    end
    nib_lo = !nib_lo;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (chk_fall) begin
      chk("busy_fall", {31'd0, busy}, 32'd0);
      chk("rw_fall", {31'd0, lcd_rw}, 32'd0);
      chk_fall = 1'b0;
    end
    if (lcd_e) begin
      e_run = e_run + 1;
    end else if (e_prev) begin
      chk("e_high_width", e_run, TEph);
      chk("rw_held", {31'd0, lcd_rw}, 32'd1);
      if (sb_q.size() > 0) chk("rs_held", {31'd0, lcd_rs}, {31'd0, sb_q[0].rs});
      e_run = 0;
    end
    e_prev = lcd_e;
    if (read_done) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        sb_e = sb_q.pop_front();
        chk("read_data", {24'd0, read_data}, {24'd0, sb_e.data});
        chk("timeout", {31'd0, tmo}, {31'd0, sb_e.tmo});
        chk("done_latency", cyc - t_start, sb_e.lat);
        chk_fall = 1'b1;
      end
    end
  end

  task automatic do_read(input logic rs, input logic [7:0] exp_data, input logic exp_tmo,
                         input int unsigned reads);
    @(negedge clk);
    rs_in   = rs;
    start   = 1'b1;
    t_start = cyc;
    sb_q.push_back('{data: exp_data, tmo: exp_tmo, lat: ReadLat + 4 * TEph * (reads - 1),
                     rs: rs});
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("busy_rise", {31'd0, busy}, 32'd1);
    chk("rw_rise", {31'd0, lcd_rw}, 32'd1);
    chk("rs_rise", {31'd0, lcd_rs}, {31'd0, rs});
  endtask

  task automatic pulse_start_at(input int unsigned rel);
    while (cyc - t_start < rel) @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic drain(input int unsigned budget);
    int unsigned n = 0;
    while (sb_q.size() > 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() > 0) begin
      chk("drain_timeout", sb_q.size(), 32'd0);
      sb_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #(20 * 100_000);
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_e", {31'd0, lcd_e}, 32'd0);
    chk("rst_rw", {31'd0, lcd_rw}, 32'd0);
    chk("rst_rs", {31'd0, lcd_rs}, 32'd0);
    chk("rst_data", {24'd0, read_data}, 32'd0);
    chk("rst_done", {31'd0, read_done}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_timeout", {31'd0, tmo}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Status read.
    bus_q.push_back(8'h3A);
    do_read(1'b0, 8'h3A, 1'b0, 1);
    drain(200);

    // Data read, with two ignored start pulses mid-transaction.
    bus_q.push_back(8'h41);
    do_read(1'b1, 8'h41, 1'b0, 1);
    pulse_start_at(10);
    pulse_start_at(50);
    drain(200);
    repeat (150) @(negedge clk);
    chk("busy_after_ignored", {31'd0, busy}, 32'd0);

    // Reset mid-transaction.
    bus_q.push_back(8'h77);
    do_read(1'b1, 8'h77, 1'b0, 1);
    while (cyc - t_start < 39) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_e", {31'd0, lcd_e}, 32'd0);
    chk("midrst_rw", {31'd0, lcd_rw}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, read_done}, 32'd0);
    chk("midrst_data", {24'd0, read_data}, 32'd0);
    sb_q.delete();
    bus_q.delete();
    nib_lo = 1'b0;
    e_run  = 0;
    rst = 1'b0;
    repeat (150) @(negedge clk);

    bus_q.push_back(8'h5C);
    do_read(1'b1, 8'h5C, 1'b0, 1);
    drain(200);

`ifdef LCD_BUSY_POLL_EN
    // BF=1 for three reads, then clear with AC=0x05.
    bus_q.push_back(8'h85);
    bus_q.push_back(8'hA5);
    bus_q.push_back(8'hC5);
    bus_q.push_back(8'h05);
    do_read(1'b0, 8'h05, 1'b0, 4);
    drain(600);
    chk("poll_bytes_left", bus_q.size(), 32'd0);

    // BF stuck at 1: gives up after PollMax reads.
    repeat (PollMax) bus_q.push_back(8'h9C);
    do_read(1'b0, 8'h9C, 1'b1, PollMax);
    drain(600);
    chk("stuck_bytes_left", bus_q.size(), 32'd0);
`else
    // Status with BF=1 still returns after a single read.
    bus_q.push_back(8'hB7);
    do_read(1'b0, 8'hB7, 1'b0, 1);
    drain(200);
    chk("single_bytes_left", bus_q.size(), 32'd0);
`endif

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lcd_read.md
# lcd_read

Nibble-mode read engine for the HD44780-compatible character LCD: performs RW=1 bus cycles over the 4-bit data bus and returns one byte, either the status/address byte (RS=0: busy flag + address counter) or a DDRAM/CGRAM data byte (RS=1). It sits beside the existing initialisation/write path on the same LCD pins. The top level multiplexes LCD_E/LCD_RW/LCD_RS by `busy` and never drives LCD_D while `busy`=1.

## Interface
Parameters:
- FREQ, 50000000, system clock frequency in Hz.
- T_SETUP_CYC, 2, cycles RS/RW are stable before E rises (≥40 ns).
- T_EPH_CYC, FREQ/2000000 (25), cycles per E-high and per E-low phase (500 ns each, 1 µs E cycle).
- POLL_MAX, 1023, maximum status reads in busy-poll mode.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- startRead  in  1  request pulse; sampled only in idle.
- readRS  in  1  register select for the request, captured with startRead.
- LCD_D  inout  4  LCD data bus; this block only samples it and never drives it (always high-Z).
- LCD_E  out  1  enable strobe.
- LCD_RW  out  1  1 during a transaction.
- LCD_RS  out  1  captured readRS during a transaction.
- readData  out  8  returned byte, valid from readDone onward.
- readDone  out  1  one-cycle completion pulse.
- busy  out  1  transaction in progress (pin ownership).
- timeout  out  1  poll limit reached, valid with readDone.

## Operation
- All outputs are registered. Reset values: LCD_E=0, LCD_RW=0, LCD_RS=0, readData=0, readDone=0, busy=0, timeout=0; state=idle.
- States: idle → setup → e_high_hi → e_low_hi → e_high_lo → e_low_lo → done → idle.
- idle: startRead=1 captures readRS; next state setup. busy, LCD_RW and LCD_RS assert in the following cycle.
- setup: E=0 for T_SETUP_CYC cycles.
- e_high_hi: E=1 for T_EPH_CYC cycles. LCD_D is registered into readData[7:4] on the last cycle of the phase.
- e_low_hi: E=0 for T_EPH_CYC cycles.
- e_high_lo: E=1 for T_EPH_CYC cycles. LCD_D is registered into readData[3:0] on the last cycle.
- e_low_lo: E=0 for T_EPH_CYC cycles. RW and RS stay held throughout, which covers the address hold time.
- done: readDone=1 for one cycle; busy, LCD_RW and LCD_RS drop to 0 on the next cycle.
- startRead is ignored while busy=1. No queueing.
- readData holds its last value until the next high nibble is sampled.
- RESET mid-transaction: returns to idle next edge, all outputs at reset values, no readDone.
- Phase counter is a down counter loaded with phase length −1; width is $clog2 of the largest phase length.

## Timing
- startRead sampled high at cycle 0 → readDone high at cycle 1+T_SETUP_CYC+4·T_EPH_CYC. This is 103 at defaults.
- At defaults: E rises at cycle 3, first sample at cycle 27, second sample at cycle 77.
- busy falls at cycle 104.
- Earliest next startRead accepted: the cycle busy is 0.
- E-high width is exactly T_EPH_CYC cycles. E-low width is at least T_EPH_CYC cycles.

## Configuration
- LCD_BUSY_POLL_EN defined, and the request has readRS=0: after e_low_lo, if readData[7]=1 and the attempt count is below POLL_MAX, go directly to e_high_hi (no setup, RW/RS held). Otherwise go to done.
  - Poll limit exhausted with BF still 1: timeout=1 with readDone.
  - readData in done is the last byte read.
  - Attempt counter clears in idle.
- LCD_BUSY_POLL_EN undefined: exactly one byte per request. timeout is constant 0. No attempt counter is synthesised.

## Structure
- Shared package lcd_pkg holds:
  - the state enum typedef (lcd_read_state_t);
  - FREQ and the derived timing constants (t1_uS, E phase cycles), so the write and read paths use one definition.
- Sub-module lcd_phase_timer: a loadable down counter with a zero flag. It is reused for every E phase and setup interval.

## Test plan
- Status read: bus model returns high nibble 4'h3 and low nibble 4'hA, readRS=0. Required: readData=8'h3A, readDone at cycle 103, LCD_RS=0, LCD_RW=1 throughout, E high exactly 25 cycles twice.
- Data read: readRS=1, nibbles 4'h4 and 4'h1. Required: readData=8'h41, LCD_RS=1 from cycle 1 to 103.
- startRead pulsed at cycles 10 and 50 during a transaction. Required: both ignored, exactly one readDone.
- RESET asserted at cycle 40. Required: next cycle LCD_E=0, LCD_RW=0, busy=0, no readDone; a fresh startRead then completes normally.
- LCD_BUSY_POLL_EN defined, BF=1 for 3 reads then 0 with AC=7'h05. Required: readData=8'h05, readDone at 103+3·100 = 403, timeout=0.
- LCD_BUSY_POLL_EN defined, POLL_MAX=4, BF stuck at 1. Required: readDone with timeout=1 after 4 reads (cycle 403).
